// File: rtl/cube_pkg.sv
// cube_pkg: shared definitions for the move sequencer codebase slice.
//   - game state encodings (SET / SCRAMBLING / SCRAMBLED)
//   - move op codes (0-5 face turns, 6 horizontal rotation, 7 vertical rotation)
//   - move_t: one move command {op, dir}
//   - rand_face(): folds a random 3-bit value onto the six faces
package cube_pkg;

   typedef enum logic [1:0] {
      ST_SET        = 2'd0,
      ST_SCRAMBLING = 2'd1,
      ST_SCRAMBLED  = 2'd2
   } state_e;

   localparam logic [2:0] OP_HROT   = 3'd6;
   localparam logic [2:0] OP_VROT   = 3'd7;
   localparam int         NUM_FACES = 6;
   localparam logic       DIR_CW    = 1'b1;

   typedef struct packed {
      logic [2:0] op;
      logic       dir;
   } move_t;

   // Values 6 and 7 have no face; fold them back onto faces 0 and 1.
   function automatic logic [2:0] rand_face(input logic [2:0] r);
      logic [2:0] f;
      if (r >= 3'(NUM_FACES)) begin
         f = r - 3'(NUM_FACES);
      end else begin
         f = r;
      end
      return f;
   endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// move_sequencer_if: valid/ready move command channel.
//   move_valid : move_op/move_dir are valid (driven by master)
//   move_ready : downstream accepts a move this cycle (driven by slave)
//   move_op    : 0-5 face turn, 6 hrot, 7 vrot
//   move_dir   : 1 = clockwise
interface move_sequencer_if;
   logic       move_valid;
   logic       move_ready;
   logic [2:0] move_op;
   logic       move_dir;

   modport master (output move_valid, output move_op, output move_dir, input move_ready);
   modport slave  (input move_valid, input move_op, input move_dir, output move_ready);
endinterface

// File: rtl/move_slot.sv
// move_slot: output register plus a one-entry holding slot for the move channel.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid_i   : a new request is offered this cycle
//   req_i         : the offered move
//   out_ready_i   : downstream ready
//   out_valid_o   : output register holds a valid move
//   out_o         : output move (stable while valid and not accepted)
//   slot_full_o   : holding slot occupied
// A request is taken into the output when it is free (or being emptied and
// the slot is empty), into the slot when the output is stalled, else dropped.
module move_slot
   import cube_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  req_valid_i,
   input  move_t req_i,
   input  logic  out_ready_i,
   output logic  out_valid_o,
   output move_t out_o,
   output logic  slot_full_o
);

   logic  out_valid_q;
   move_t out_q;
   logic  slot_full_q;
   move_t slot_q;

   assign out_valid_o = out_valid_q;
   assign out_o       = out_q;
   assign slot_full_o = slot_full_q;

   // Output/slot register update following the valid/ready rules.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         slot_full_q <= 1'b0;
         slot_q      <= '0;
      end else if (!out_valid_q || out_ready_i) begin
         // Output is free or being accepted: refill it, slot first (no bubble).
         if (slot_full_q) begin
            out_q       <= slot_q;
            out_valid_q <= 1'b1;
            slot_full_q <= req_valid_i;
            if (req_valid_i) begin
               slot_q <= req_i;
            end
         end else if (req_valid_i) begin
            out_q       <= req_i;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (req_valid_i && !slot_full_q) begin
         slot_q      <= req_i;
         slot_full_q <= 1'b1;
      end
   end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: merges button pulses, switches and LFSR values into one
// valid/ready stream of cube moves and owns the game state and move counter.
//   clk             : system clock
//   btn_reset       : synchronous active-high reset
//   sw[7:0]         : sw[2:0] face for cw/ccw, sw[7] scramble request
//   is_*_posedge    : one-cycle button pulses (cw, ccw, hrot, vrot)
//   randclk         : slow scramble tick, sampled as data
//   rand_num[3:0]   : LFSR nibble ([2:0] face, [3] dir)
//   mv              : move channel (master side)
//   state[1:0]      : 0 SET, 1 SCRAMBLING, 2 SCRAMBLED
//   move_count      : face turns since the scramble completed (saturating)
// Optional: define MOVE_SEQ_NO_UNDO_EN to turn a random move that would undo
// the previous scramble move into a repeat of it.
module move_sequencer
   import cube_pkg::*;
#(
   parameter int SCRAMBLE_LEN = 25,
   parameter int COUNT_W      = 13
)(
   input  logic               clk,
   input  logic               btn_reset,
   input  logic [7:0]         sw,
   input  logic               is_cw_posedge,
   input  logic               is_ccw_posedge,
   input  logic               is_hrot_posedge,
   input  logic               is_vrot_posedge,
   input  logic               randclk,
   input  logic [3:0]         rand_num,
   move_sequencer_if.master   mv,
   output logic [1:0]         state,
   output logic [COUNT_W-1:0] move_count
);

   localparam logic [7:0]         SCR_LAST = 8'(SCRAMBLE_LEN - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

   state_e             state_q;
   logic [7:0]         scr_cnt_q;
   logic [COUNT_W-1:0] move_count_q;
   logic               rc_q;

   logic       req_valid_s;
   move_t      req_s;
   move_t      out_s;
   logic       slot_full_s;
   logic       busy_s;
   logic       xfer_s;
   logic       rc_rise_s;
   logic       go_scr_s;
   logic [2:0] rand_face_s;
   logic       rand_dir_s;
   logic       unused_s;

`ifdef MOVE_SEQ_NO_UNDO_EN
   move_t prev_q;
   logic  prev_valid_q;
`endif

   assign unused_s   = ^sw[6:3];
   assign busy_s     = mv.move_valid | slot_full_s;
   assign xfer_s     = mv.move_valid & mv.move_ready;
   assign rc_rise_s  = randclk & ~rc_q;
   assign go_scr_s   = (state_q == ST_SET) && sw[7] && !busy_s && !req_valid_s;
   assign mv.move_op  = out_s.op;
   assign mv.move_dir = out_s.dir;
   assign state      = state_q;
   assign move_count = move_count_q;

   // Request generation: button arbitration or random scramble move.
   always_comb begin
      req_valid_s = 1'b0;
      req_s       = '0;
      rand_face_s = rand_face(rand_num[2:0]);
      rand_dir_s  = rand_num[3];
`ifdef MOVE_SEQ_NO_UNDO_EN
      if (prev_valid_q && (prev_q.op == rand_face_s) && (prev_q.dir != rand_dir_s)) begin
         rand_dir_s = prev_q.dir;
      end else begin
         rand_dir_s = rand_num[3];
      end
`endif
      case (state_q)
         ST_SET, ST_SCRAMBLED: begin
            // cw wins even if its face is invalid; the lower-priority pulses are lost.
            if (is_cw_posedge) begin
               req_valid_s = (sw[2:0] < 3'(NUM_FACES));
               req_s       = '{op: sw[2:0], dir: DIR_CW};
            end else if (is_ccw_posedge) begin
               req_valid_s = (sw[2:0] < 3'(NUM_FACES));
               req_s       = '{op: sw[2:0], dir: ~DIR_CW};
            end else if (is_hrot_posedge) begin
               req_valid_s = 1'b1;
               req_s       = '{op: OP_HROT, dir: DIR_CW};
            end else if (is_vrot_posedge) begin
               req_valid_s = 1'b1;
               req_s       = '{op: OP_VROT, dir: DIR_CW};
            end else begin
               req_valid_s = 1'b0;
            end
         end
         ST_SCRAMBLING: begin
            // A tick while anything is outstanding is skipped, never queued.
            if (rc_rise_s && !busy_s) begin
               req_valid_s = 1'b1;
               req_s       = '{op: rand_face_s, dir: rand_dir_s};
            end else begin
               req_valid_s = 1'b0;
            end
         end
         default: begin
            req_valid_s = 1'b0;
         end
      endcase
   end

   move_slot u_slot (
      .clk         (clk),
      .rst         (btn_reset),
      .req_valid_i (req_valid_s),
      .req_i       (req_s),
      .out_ready_i (mv.move_ready),
      .out_valid_o (mv.move_valid),
      .out_o       (out_s),
      .slot_full_o (slot_full_s)
   );

   // Game state FSM, scramble counter and user move counter.
   always_ff @(posedge clk) begin
      if (btn_reset) begin
         state_q      <= ST_SET;
         scr_cnt_q    <= 8'd0;
         move_count_q <= '0;
         rc_q         <= 1'b0;
      end else begin
         rc_q <= randclk;
         case (state_q)
            ST_SET: begin
               if (go_scr_s) begin
                  state_q   <= ST_SCRAMBLING;
                  scr_cnt_q <= 8'd0;
               end
            end
            ST_SCRAMBLING: begin
               if (xfer_s) begin
                  scr_cnt_q <= scr_cnt_q + 8'd1;
                  if (scr_cnt_q == SCR_LAST) begin
                     state_q      <= ST_SCRAMBLED;
                     move_count_q <= '0;
                  end
               end
            end
            ST_SCRAMBLED: begin
               if (xfer_s && (mv.move_op < OP_HROT) && (move_count_q != CNT_MAX)) begin
                  move_count_q <= move_count_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= ST_SET;
            end
         endcase
      end
   end

`ifdef MOVE_SEQ_NO_UNDO_EN
   // Remember the last issued scramble move; forgotten at reset and scramble start.
   always_ff @(posedge clk) begin
      if (btn_reset || go_scr_s) begin
         prev_valid_q <= 1'b0;
         prev_q       <= '0;
      end else if ((state_q == ST_SCRAMBLING) && req_valid_s) begin
         prev_valid_q <= 1'b1;
         prev_q       <= req_s;
      end
   end
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed test-plan items plus
// randomized phases, all compared against a queue-based transaction model.
module tb_move_sequencer;

   localparam int SLEN = 4;
   localparam int CMAX = 8191;

   logic        clk = 1'b0;
   logic        btn_reset;
   logic [7:0]  sw;
   logic        is_cw, is_ccw, is_hrot, is_vrot;
   logic        randclk;
   logic [3:0]  rand_num;
   logic        move_ready;
   logic [1:0]  state;
   logic [12:0] move_count;

   always #5 clk = ~clk;

   move_sequencer_if mif();
   assign mif.move_ready = move_ready;

   move_sequencer #(.SCRAMBLE_LEN(SLEN), .COUNT_W(13)) dut (
      .clk             (clk),
      .btn_reset       (btn_reset),
      .sw              (sw),
      .is_cw_posedge   (is_cw),
      .is_ccw_posedge  (is_ccw),
      .is_hrot_posedge (is_hrot),
      .is_vrot_posedge (is_vrot),
      .randclk         (randclk),
      .rand_num        (rand_num),
      .mv              (mif),
      .state           (state),
      .move_count      (move_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: pending moves as a queue (output = head, max 2 entries).
   int q_op[$];
   int q_dir[$];
   int m_state = 0, m_scr = 0, m_cnt = 0;
   bit m_rc = 0, m_pv = 0;
   int m_pop = 0, m_pdir = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_step();
      int r_op = 0, r_dir = 0;
      bit has = 0, busy, xfer, go;
      if (btn_reset) begin
         q_op.delete(); q_dir.delete();
         m_state = 0; m_scr = 0; m_cnt = 0; m_rc = 0; m_pv = 0;
         return;
      end
      busy = (q_op.size() > 0);
      xfer = busy && move_ready;
      if (m_state != 1) begin
         if (is_cw)        begin has = (sw[2:0] < 6); r_op = sw[2:0]; r_dir = 1; end
         else if (is_ccw)  begin has = (sw[2:0] < 6); r_op = sw[2:0]; r_dir = 0; end
         else if (is_hrot) begin has = 1; r_op = 6; r_dir = 1; end
         else if (is_vrot) begin has = 1; r_op = 7; r_dir = 1; end
      end else if (randclk && !m_rc && !busy) begin
         r_op  = int'(rand_num[2:0]) % 6;
         r_dir = rand_num[3];
`ifdef MOVE_SEQ_NO_UNDO_EN
         if (m_pv && m_pop == r_op && m_pdir != r_dir) r_dir = m_pdir;
`endif
         has = 1; m_pv = 1; m_pop = r_op; m_pdir = r_dir;
      end
      go = (m_state == 0) && sw[7] && !busy && !has;
      m_rc = randclk;
      if (xfer) begin
         if (m_state == 1) begin
            m_scr++;
            if (m_scr == SLEN) begin m_state = 2; m_cnt = 0; end
         end else if (m_state == 2 && q_op[0] < 6 && m_cnt < CMAX) begin
            m_cnt++;
         end
         void'(q_op.pop_front());
         void'(q_dir.pop_front());
      end
      if (has && q_op.size() < 2) begin
         q_op.push_back(r_op);
         q_dir.push_back(r_dir);
      end
      if (go) begin m_state = 1; m_scr = 0; m_pv = 0; end
   endtask

   task automatic compare_all();
      check_eq("valid", 32'(mif.move_valid), 32'(q_op.size() > 0));
      if (q_op.size() > 0) begin
         check_eq("op", 32'(mif.move_op), q_op[0]);
         check_eq("dir", 32'(mif.move_dir), q_dir[0]);
      end
      check_eq("state", 32'(state), m_state);
      check_eq("count", 32'(move_count), m_cnt);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic clr_pulses();
      is_cw = 0; is_ccw = 0; is_hrot = 0; is_vrot = 0;
   endtask

   task automatic rand_pulses();
      is_cw   = ($urandom_range(0, 5) == 0);
      is_ccw  = ($urandom_range(0, 5) == 0);
      is_hrot = ($urandom_range(0, 5) == 0);
      is_vrot = ($urandom_range(0, 5) == 0);
   endtask

   initial begin
      btn_reset = 1; sw = 8'd0; clr_pulses(); randclk = 0; rand_num = 4'd0; move_ready = 0;
      tick(); tick();
      check_eq("rst_valid", 32'(mif.move_valid), 0);
      check_eq("rst_state", 32'(state), 0);
      check_eq("rst_count", 32'(move_count), 0);
      btn_reset = 0;

      // Single cw pass-through in SET, one-cycle latency.
      move_ready = 1; sw = 8'd3; is_cw = 1; tick(); clr_pulses();
      check_eq("cw_valid", 32'(mif.move_valid), 1);
      check_eq("cw_op", 32'(mif.move_op), 3);
      check_eq("cw_dir", 32'(mif.move_dir), 1);
      tick();
      check_eq("cw_gone", 32'(mif.move_valid), 0);
      check_eq("set_count", 32'(move_count), 0);

      // cw beats vrot in the same cycle.
      sw = 8'd2; is_cw = 1; is_vrot = 1; tick(); clr_pulses();
      check_eq("prio_op", 32'(mif.move_op), 2);
      tick();
      check_eq("prio_drop", 32'(mif.move_valid), 0);

      // Stall: output holds hrot, slot holds vrot, cw dropped, then no bubble.
      move_ready = 0; sw = 8'd1;
      is_hrot = 1; tick(); clr_pulses();
      is_vrot = 1; tick(); clr_pulses();
      is_cw = 1;   tick(); clr_pulses();
      check_eq("stall_op", 32'(mif.move_op), 6);
      move_ready = 1; tick();
      check_eq("slot_op", 32'(mif.move_op), 7);
      check_eq("slot_valid", 32'(mif.move_valid), 1);
      tick();
      check_eq("drain_valid", 32'(mif.move_valid), 0);

      // Random traffic in SET.
      for (int i = 0; i < 300; i++) begin
         rand_pulses(); sw = 8'($urandom_range(0, 7)); move_ready = $urandom_range(0, 1);
         tick();
      end
      clr_pulses(); move_ready = 1; tick(); tick(); tick();

      // Directed scramble: rand_num 7 -> face 1, ccw; buttons ignored.
      sw = 8'h80; rand_num = 4'd7;
      for (int i = 0; i < 40; i++) begin
         randclk = ((i / 3) % 2 == 1);
         if (m_state == 1) rand_pulses(); else clr_pulses();
         tick();
         if (mif.move_valid && m_state == 1) begin
            check_eq("scr_op", 32'(mif.move_op), 1);
            check_eq("scr_dir", 32'(mif.move_dir), 0);
         end
      end
      clr_pulses();
      check_eq("scr_done", 32'(state), 2);
      check_eq("scr_count", 32'(move_count), 0);

      // SCRAMBLED: 3 face turns and 2 rotations counted as 3.
      sw = 8'h80;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) is_cw = 1; else is_hrot = 1;
         tick(); clr_pulses(); tick();
      end
      check_eq("user_count", 32'(move_count), 3);

      // Random traffic in SCRAMBLED.
      for (int i = 0; i < 300; i++) begin
         rand_pulses(); sw = 8'($urandom_range(0, 255)); move_ready = $urandom_range(0, 1);
         tick();
      end
      clr_pulses();

      // Random scramble with random ready and random LFSR values.
      btn_reset = 1; tick(); btn_reset = 0; sw = 8'h80;
      for (int i = 0; i < 300; i++) begin
         rand_num = 4'($urandom_range(0, 15)); randclk = $urandom_range(0, 1);
         move_ready = ($urandom_range(0, 3) != 0);
         if (m_state == 1) rand_pulses(); else clr_pulses();
         tick();
      end
      clr_pulses(); move_ready = 1;
      for (int i = 0; i < 60; i++) begin randclk = ((i / 2) % 2 == 1); tick(); end
      check_eq("rscr_state", 32'(state), 2);

      // Saturation of move_count.
      sw = 8'h80; is_cw = 1;
      for (int i = 0; i < 8250; i++) tick();
      clr_pulses(); tick(); tick();
      check_eq("sat_count", 32'(move_count), CMAX);
      is_cw = 1; tick(); clr_pulses(); tick();
      check_eq("sat_hold", 32'(move_count), CMAX);

      // Reset mid-scramble with a stalled move.
      move_ready = 0; btn_reset = 1; randclk = 0; tick(); btn_reset = 0;
      tick(); tick(); randclk = 1; tick(); tick();
      check_eq("mid_valid", 32'(mif.move_valid), 1);
      btn_reset = 1; tick();
      check_eq("mid_state", 32'(state), 0);
      check_eq("mid_vout", 32'(mif.move_valid), 0);
      check_eq("mid_count", 32'(move_count), 0);

      // Undo suppression sequence.
      randclk = 0; move_ready = 1; tick(); btn_reset = 0;
      tick();
      rand_num = 4'b1010; randclk = 1; tick();
      check_eq("undo1_op", 32'(mif.move_op), 2);
      check_eq("undo1_dir", 32'(mif.move_dir), 1);
      randclk = 0; tick();
      rand_num = 4'b0010; randclk = 1; tick();
      check_eq("undo2_op", 32'(mif.move_op), 2);
`ifdef MOVE_SEQ_NO_UNDO_EN
      check_eq("undo2_dir", 32'(mif.move_dir), 1);
`else
      check_eq("undo2_dir", 32'(mif.move_dir), 0);
`endif
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
